// File: rtl/pixel_compositor.sv
// Per-pixel layer compositor: priority colour select, blanking,
// per-frame collision report and frame-counted blink.
module pixel_compositor #(
  parameter int NUM_LAYERS = 4,
  parameter int RED_W = 3,
  parameter int GRN_W = 3,
  parameter int BLU_W = 2,
  parameter int COLOR_W = RED_W + GRN_W + BLU_W,
  parameter logic [NUM_LAYERS-1:0] COLL_MASK = NUM_LAYERS'(4'b0011),
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_LAYERS-1:0] layer_hit,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
  input  logic [NUM_LAYERS-1:0] blink_en,
  input  logic [COLOR_W-1:0] bg_color,
  input  logic [COLOR_W-1:0] idle_color,
  input  logic game,
  input  logic rgbactive,
  input  logic frame_start,
  output logic [RED_W-1:0] red,
  output logic [GRN_W-1:0] grn,
  output logic [BLU_W-1:0] blu,
  output logic collision,
  output logic blink_phase
);

  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int PCW = $clog2(NUM_LAYERS + 1) + 1;
  localparam logic [FCW-1:0] FC_LAST = FCW'(BLINK_FRAMES - 1);

  logic [NUM_LAYERS-1:0] vis;
  logic [COLOR_W-1:0] sel;
  logic [COLOR_W-1:0] nxt;
  logic [COLOR_W-1:0] rgb_q;
  logic [PCW-1:0] pc;
  logic hit_now;
  logic coll_live;
  logic [FCW-1:0] frame_cnt;

  assign vis = layer_hit & ~(blink_en & {NUM_LAYERS{blink_phase}});

  // Walk from lowest priority up so the lowest visible index wins.
  always_comb begin
    sel = bg_color;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (vis[i]) sel = layer_color[i*COLOR_W +: COLOR_W];
    end
  end

  always_comb begin
    nxt = '0;
    if (!rgbactive) nxt = '0;
    else if (!game) nxt = idle_color;
    else nxt = sel;
  end

  always_comb begin
    pc = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      pc = pc + PCW'(layer_hit[i] & COLL_MASK[i]);
    end
  end

  assign hit_now = rgbactive & game & (pc >= PCW'(2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= nxt;
    end
  end

  // A hit on the frame_start cycle belongs to the frame just ended.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll_live <= 1'b0;
      collision <= 1'b0;
    end else if (frame_start) begin
      collision <= coll_live | hit_now;
      coll_live <= 1'b0;
    end else begin
      coll_live <= coll_live | hit_now;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt == FC_LAST) begin
        frame_cnt <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign red = rgb_q[COLOR_W-1 -: RED_W];
  assign grn = rgb_q[BLU_W +: GRN_W];
  assign blu = rgb_q[BLU_W-1:0];

endmodule

// File: tb/tb_pixel_compositor.sv
// Scoreboard bench for pixel_compositor with a 2-frame blink
// and collisions between layers 0 and 1.
module tb_pixel_compositor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] hit = '0;
  logic [31:0] lc;
  logic [3:0] ben = '0;
  logic [7:0] bg = 8'h03;
  logic [7:0] idle = 8'h02;
  logic game = 1'b0;
  logic act = 1'b0;
  logic fs = 1'b0;
  logic [2:0] red;
  logic [2:0] grn;
  logic [1:0] blu;
  logic collision;
  logic blink_phase;

  int n_run = 0;
  int n_fail = 0;
  logic [7:0] sb[$];

  logic m_coll = 1'b0;
  logic m_live = 1'b0;
  logic m_phase = 1'b0;
  int m_cnt = 0;

  pixel_compositor #(
    .NUM_LAYERS(4),
    .COLL_MASK(4'b0011),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .layer_hit(hit),
    .layer_color(lc),
    .blink_en(ben),
    .bg_color(bg),
    .idle_color(idle),
    .game(game),
    .rgbactive(act),
    .frame_start(fs),
    .red(red),
    .grn(grn),
    .blu(blu),
    .collision(collision),
    .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_rgb();
    logic [7:0] c;
    if (!act) return 8'h00;
    if (!game) return idle;
    c = bg;
    for (int i = 3; i >= 0; i--)
      if (hit[i] && !(ben[i] && m_phase)) c = lc[i*8 +: 8];
    return c;
  endfunction

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic cyc();
    logic hn;
    int pc;
    sb.push_back(model_rgb());
    pc = int'(hit[0]) + int'(hit[1]);
    hn = act && game && (pc >= 2);
    @(posedge clk);
    if (fs) begin
      m_coll = m_live | hn;
      m_live = 1'b0;
      if (m_cnt == 1) begin
        m_cnt = 0;
        m_phase = ~m_phase;
      end else begin
        m_cnt++;
      end
    end else begin
      m_live = m_live | hn;
    end
    #1;
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else chk("rgb", {red, grn, blu}, sb.pop_front());
    chk("coll", collision, m_coll);
    chk("phase", blink_phase, m_phase);
    @(negedge clk);
  endtask

  task automatic frame(input logic [3:0] h);
    hit = h;
    fs = 1'b1;
    cyc();
    fs = 1'b0;
    hit = '0;
  endtask

  initial begin
    lc = {8'h92, 8'h1C, 8'hE0, 8'h1F};
    #2;
    chk("rst_rgb", {red, grn, blu}, 8'h00);
    chk("rst_coll", collision, 0);
    chk("rst_phase", blink_phase, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    game = 1'b1;
    act = 1'b1;

    hit = 4'b0110; cyc();
    chk("prio", {red, grn, blu}, 8'hE0);
    hit = 4'b0000; cyc();
    chk("bg", {red, grn, blu}, 8'h03);
    act = 1'b0; hit = 4'b1111; cyc();
    chk("blank", {red, grn, blu}, 8'h00);
    act = 1'b1; game = 1'b0; cyc();
    chk("idle", {red, grn, blu}, 8'h02);
    game = 1'b1; hit = '0;

    frame(4'b0000);
    hit = 4'b0011; cyc();
    chk("l0", {red, grn, blu}, 8'h1F);
    hit = 4'b0000; cyc();
    frame(4'b0000);
    chk("coll_set", collision, 1);
    chk("phase_t1", blink_phase, 1);
    frame(4'b0000);
    chk("coll_clr", collision, 0);
    frame(4'b0011);
    chk("coll_fs", collision, 1);
    frame(4'b0000);
    chk("coll_fs_once", collision, 0);

    hit = 4'b1100; cyc();
    act = 1'b0; hit = 4'b0011; cyc();
    act = 1'b1;
    frame(4'b0000);
    chk("coll_mask", collision, 0);
    chk("phase_t2", blink_phase, 1);

    ben = 4'b0001;
    hit = 4'b0001; cyc();
    chk("blink_bg", {red, grn, blu}, 8'h03);
    hit = 4'b0011; cyc();
    chk("blink_l1", {red, grn, blu}, 8'hE0);
    frame(4'b0000);
    chk("blink_coll", collision, 1);
    frame(4'b0000);
    chk("phase_t3", blink_phase, 0);
    hit = 4'b0001; cyc();
    chk("blink_on", {red, grn, blu}, 8'h1F);

    frame(4'b0000);
    frame(4'b0000);
    hit = 4'b0011; cyc();
    frame(4'b0000);
    chk("pre_coll", collision, 1);
    chk("pre_phase", blink_phase, 1);
    hit = 4'b0011; cyc();
    hit = 4'b0010; cyc();

    #2;
    rst = 1'b1;
    hit = '0;
    #1;
    chk("arst_rgb", {red, grn, blu}, 8'h00);
    chk("arst_coll", collision, 0);
    chk("arst_phase", blink_phase, 0);
    sb.delete();
    m_coll = 1'b0;
    m_live = 1'b0;
    m_phase = 1'b0;
    m_cnt = 0;
    @(negedge clk);
    rst = 1'b0;

    frame(4'b0000);
    chk("post_coll", collision, 0);
    chk("post_phase1", blink_phase, 0);
    frame(4'b0011);
    chk("post_coll2", collision, 1);
    chk("post_phase2", blink_phase, 1);

    for (int k = 0; k < 40; k++) begin
      hit = 4'($urandom_range(0, 15));
      ben = 4'($urandom_range(0, 15));
      act = 1'($urandom_range(0, 3) != 0);
      game = 1'($urandom_range(0, 5) != 0);
      fs = 1'($urandom_range(0, 7) == 0);
      cyc();
    end
    fs = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_compositor.md
# pixel_compositor

Parametrised per-pixel colour compositor for the VGA path. Takes N priority-ordered layer hit flags (paddle, ball, carpet, …) from the object generators, selects one colour per pixel, blanks outside the active area and registers the RGB drive to the DAC pins. Also produces a per-frame sticky collision flag between selected layers and a frame-counted blink for selected layers. Sits between the object generators and the top-level VGA outputs, replacing fixed per-bit colour wiring.

## Interface
- NUM_LAYERS, 4, number of layer inputs; index 0 is the highest priority.
- RED_W, 3, red channel width.
- GRN_W, 3, green channel width.
- BLU_W, 2, blue channel width; COLOR_W = RED_W+GRN_W+BLU_W, packed {red,grn,blu}.
- COLL_MASK, 4'b0011, layers that take part in collision detection.
- BLINK_FRAMES, 30, frames per blink half-period; must be at least 1.

- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- layer_hit  in  NUM_LAYERS  current pixel is covered by layer i.
- layer_color  in  NUM_LAYERS*COLOR_W  colour of layer i in slice [i*COLOR_W +: COLOR_W].
- blink_en  in  NUM_LAYERS  layer i is hidden during the blink-off phase.
- bg_color  in  COLOR_W  colour used in the active area when no layer is shown.
- idle_color  in  COLOR_W  colour used in the active area when game=0.
- game  in  1  1 = game running, 0 = idle/attract screen.
- rgbactive  in  1  pixel is in the visible area.
- frame_start  in  1  one-cycle pulse on the first cycle of each frame.
- red  out  RED_W  registered red drive.
- grn  out  GRN_W  registered green drive.
- blu  out  BLU_W  registered blue drive.
- collision  out  1  at least two COLL_MASK layers overlapped in a visible pixel of the previous frame.
- blink_phase  out  1  current blink phase; 1 = blink-off.

## Operation
- Visible layers: vis[i] = layer_hit[i] & ~(blink_en[i] & blink_phase).
- Colour select: the lowest i with vis[i]=1 supplies its layer_color. If no layer is visible, bg_color is used.
- Mode priority, highest first:
  - rgbactive=0: output 0.
  - game=0: output idle_color.
  - otherwise: the colour select result.
- Collision uses the raw layer_hit values, not vis, so blinked layers still collide.
  - hit_now = rgbactive & game & (popcount(layer_hit & COLL_MASK) ≥ 2).
  - coll_live is sticky within a frame.
- On frame_start: collision <= coll_live | hit_now, then coll_live <= 0.
  - A hit in the frame_start cycle counts toward the frame just ended, and only that frame.
  - Otherwise coll_live <= coll_live | hit_now.
- Blink:
  - frame_cnt counts frame_start pulses from 0 to BLINK_FRAMES-1.
  - On the pulse where frame_cnt = BLINK_FRAMES-1: frame_cnt wraps to 0 and blink_phase toggles.
  - frame_cnt width is clog2(BLINK_FRAMES), minimum 1 bit.
- NUM_LAYERS=1 is legal. With fewer than 2 bits set in COLL_MASK, collision stays 0.

## Timing
- Latency: inputs at edge k produce red/grn/blu at edge k+1, with one register stage. No combinational path from inputs to outputs.
- blink_phase used in vis is the registered value. A toggle takes effect on the pixel after the toggling frame_start.
- collision updates on the edge that samples frame_start and holds for the whole frame.
- Reset, asynchronous, any time including mid-frame:
  - red, grn, blu, collision, blink_phase, coll_live and frame_cnt all go to 0.
  - The first frame_start after reset reports collision = hit_now of that cycle only.
- frame_start held high for multiple cycles counts each cycle. The driver guarantees one-cycle pulses.

## Test plan
- Priority: NUM_LAYERS=4, layer_hit=4'b0110, layer1 colour 8'hE0, layer2 colour 8'h1C, game=1, rgbactive=1 -> next cycle {red,grn,blu}=8'hE0. With layer_hit=0 and bg_color=8'h03 -> 8'h03.
- Blanking and idle:
  - rgbactive=0 with any hits -> outputs 0 one cycle later.
  - rgbactive=1, game=0, idle_color=8'h02 -> 8'h02.
- Collision: layer_hit[1:0]=2'b11 for one visible pixel mid-frame -> collision=1 after the next frame_start. It returns to 0 after the following frame_start if no further overlap occurs. Overlap in a frame_start cycle -> collision=1 for that report, not the next.
- Collision masking: layer_hit=4'b1100 with COLL_MASK=4'b0011 -> collision stays 0. Overlap with rgbactive=0 -> collision stays 0.
- Blink: BLINK_FRAMES=2, blink_en[0]=1, layer0 hit -> blink_phase toggles every 2nd frame_start. While blink_phase=1, layer0 is hidden and the next layer or bg_color shows. Collision still detects layer0.
- Reset mid-frame: assert rst with collision=1, blink_phase=1 and frame_cnt nonzero -> all outputs 0 immediately without a clock edge. After release, blink needs a full BLINK_FRAMES count before toggling.
